// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter (double dabble, one input bit per clock).
// The result register only changes on the completing edge, so displays never show partial values.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_LOAD = CW'(WIDTH);

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    state_t              state, state_next;
    logic [WIDTH-1:0]    bin_sr, bin_sr_next;
    logic [4*DIGITS-1:0] bcd_sr, bcd_sr_next;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [4*DIGITS-1:0] bcd_out_next;
    logic [CW-1:0]       count, count_next;
    logic                done_next;
    logic                busy_next;

    // Add 3 to every digit that is 5 or more, so the following shift carries into the next decade.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_next   = state;
        bin_sr_next  = bin_sr;
        bcd_sr_next  = bcd_sr;
        count_next   = count;
        bcd_out_next = bcd_out;
        done_next    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    bin_sr_next = bin_in;
                    bcd_sr_next = '0;
                    count_next  = COUNT_LOAD;
                    state_next  = CONVERT;
                end
            end
            CONVERT: begin
                bcd_sr_next = {bcd_adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
                bin_sr_next = {bin_sr[WIDTH-2:0], 1'b0};
                count_next  = count - 1'b1;
                if (count == {{(CW-1){1'b0}}, 1'b1}) begin
                    bcd_out_next = bcd_sr_next;
                    done_next    = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == CONVERT);
    end

    // Reset aborts any conversion in flight and wins over a coincident start.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= IDLE;
            bin_sr  <= '0;
            bcd_sr  <= '0;
            count   <= '0;
            bcd_out <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            bin_sr  <= bin_sr_next;
            bcd_sr  <= bcd_sr_next;
            count   <= count_next;
            bcd_out <= bcd_out_next;
            done    <= done_next;
            busy    <= busy_next;
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed table, multi-cycle corner cases
// and a random sweep against a decimal-arithmetic reference.
module tb_bin_to_bcd_seq;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;

    int assertions;
    int failures;

    typedef struct {
        logic [15:0] value;
        logic [19:0] expected;
    } vec_t;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Decimal reference built from plain division: digit i is (v / 10^i) % 10.
    function automatic logic [19:0] refBcd(input int unsigned v);
        logic [19:0] r;
        int unsigned rest;
        r    = '0;
        rest = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(rest % 10);
            rest        = rest / 10;
        end
        return r;
    endfunction

    function automatic logic anyBadDigit(input logic [19:0] b);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (b[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Issues one start pulse and follows the conversion until done (bounded wait).
    // Returns at the falling edge where done is high, or after the bound expires.
    task automatic applyStimulus(input logic [15:0] value, output int latency,
                                 output int busyCycles, output logic gotDone);
        @(negedge clock);
        bin_in = value;
        start  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start      = 1'b0;
        bin_in     = 16'($urandom);
        latency    = -1;
        busyCycles = 0;
        gotDone    = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            if (done) begin
                latency = c;
                gotDone = 1'b1;
                break;
            end
            if (busy) busyCycles++;
            @(negedge clock);
        end
    endtask

    vec_t        vectors[6];
    int          latency;
    int          busyCycles;
    logic        gotDone;
    logic [19:0] heldValue;
    int          doneCount;
    int          doneAt[2];
    logic [19:0] doneVal[2];
    logic [15:0] r;

    initial begin
        assertions = 0;
        failures   = 0;
        resetn     = 1'b0;
        start      = 1'b0;
        bin_in     = '0;

        vectors[0] = '{16'd0,     20'h00000};
        vectors[1] = '{16'd65535, 20'h65535};
        vectors[2] = '{16'd1234,  20'h01234};
        vectors[3] = '{16'd9,     20'h00009};
        vectors[4] = '{16'd10,    20'h00010};
        vectors[5] = '{16'd59999, 20'h59999};

        repeat (3) @(negedge clock);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset bcd_out", 32'(bcd_out), 32'd0);
        resetn = 1'b1;

        $display("[TB] directed table");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vectors[i].value, latency, busyCycles, gotDone);
            checkOutput($sformatf("table[%0d] done seen", i), 32'(gotDone), 32'd1);
            checkOutput($sformatf("table[%0d] latency", i), 32'(latency), 32'd16);
            checkOutput($sformatf("table[%0d] busy cycles", i), 32'(busyCycles), 32'd16);
            checkOutput($sformatf("table[%0d] busy with done", i), 32'(busy), 32'd0);
            checkOutput($sformatf("table[%0d] bcd_out", i), 32'(bcd_out), 32'(vectors[i].expected));
            @(negedge clock);
            checkOutput($sformatf("table[%0d] done width", i), 32'(done), 32'd0);
            checkOutput($sformatf("table[%0d] bcd held", i), 32'(bcd_out), 32'(vectors[i].expected));
        end

        $display("[TB] start while busy is dropped");
        heldValue = bcd_out;
        @(negedge clock);
        bin_in = 16'd4321;
        start  = 1'b1;
        @(posedge clock);
        doneCount = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            start = (c == 5);
            if (c == 5) bin_in = 16'd999;
            if (c == 8) checkOutput("bcd_out frozen mid-conversion", 32'(bcd_out), 32'(heldValue));
            if (done) begin
                doneCount++;
                checkOutput("busy-start latency", 32'(c), 32'd16);
                checkOutput("busy-start result", 32'(bcd_out), 32'h04321);
            end
        end
        checkOutput("busy-start done count", 32'(doneCount), 32'd1);

        $display("[TB] start held high back to back");
        @(negedge clock);
        bin_in = 16'd500;
        start  = 1'b1;
        @(posedge clock);
        doneCount = 0;
        for (int c = 0; c <= 50; c++) begin
            @(negedge clock);
            if (c == 0)  bin_in = 16'd501;
            if (c == 17) start = 1'b0;
            if (done && doneCount < 2) begin
                doneAt[doneCount]  = c;
                doneVal[doneCount] = bcd_out;
                doneCount++;
            end
        end
        checkOutput("held-start done count", 32'(doneCount), 32'd2);
        if (doneCount == 2) begin
            checkOutput("held-start first done", 32'(doneAt[0]), 32'd16);
            checkOutput("held-start spacing", 32'(doneAt[1] - doneAt[0]), 32'd17);
            checkOutput("held-start first value", 32'(doneVal[0]), 32'h00500);
            checkOutput("held-start second value", 32'(doneVal[1]), 32'h00501);
        end

        $display("[TB] reset mid-conversion");
        @(negedge clock);
        bin_in = 16'd777;
        start  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        resetn = 1'b0;
        start  = 1'b1;
        @(negedge clock);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort bcd_out", 32'(bcd_out), 32'd0);
        start  = 1'b0;
        resetn = 1'b1;
        @(negedge clock);
        checkOutput("start during reset ignored", 32'(busy), 32'd0);
        doneCount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done) doneCount++;
        end
        checkOutput("aborted conversion silent", 32'(doneCount), 32'd0);
        applyStimulus(16'd42, latency, busyCycles, gotDone);
        checkOutput("post-abort done seen", 32'(gotDone), 32'd1);
        checkOutput("post-abort bcd_out", 32'(bcd_out), 32'h00042);

        $display("[TB] random sweep");
        for (int n = 0; n < 1000; n++) begin
            r = 16'($urandom);
            applyStimulus(r, latency, busyCycles, gotDone);
            checkOutput($sformatf("rand %0d latency", r), 32'(latency), 32'd16);
            checkOutput($sformatf("rand %0d digits", r), 32'(anyBadDigit(bcd_out)), 32'd0);
            checkOutput($sformatf("rand %0d bcd_out", r), 32'(bcd_out), 32'(refBcd(32'(r))));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the 7-segment decoders on the display path. It accepts an unsigned binary word, such as a register or PC value from the control unit, on a start strobe. It converts the word iteratively using shift-add-3 (double dabble), one bit per clock. The result is a bank of 4-bit decimal digits, and each digit feeds one `dec_7seg` instance's `hex_digit` input.

## Interface
- `WIDTH`, default 16: width of the binary input.
- `DIGITS`, default 5: number of BCD output digits. Legal only if 10^DIGITS > 2^WIDTH − 1.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `resetn`  in  1: reset, synchronous, active-low.
- `start`  in  1: conversion request; sampled only in IDLE.
- `bin_in`  in  WIDTH: unsigned value to convert; sampled on the accepted `start` edge.
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: one-cycle pulse when `bcd_out` has just been updated.
- `bcd_out`  out  4*DIGITS: packed BCD result; digit i is `[4i+3:4i]`, and digit 0 is units. Held between conversions.

## Operation
- States: IDLE, CONVERT.
- IDLE:
  - On an edge with `start`=1: latch `bin_in` into shift register `bin_sr`, clear scratch `bcd_sr` (4*DIGITS bits), load `count` = WIDTH, go to CONVERT.
  - Otherwise hold.
- CONVERT, once per edge:
  - For every nibble of `bcd_sr` with value ≥ 5, add 3 (nibbles are independent, no carry between them).
  - Then shift the concatenation {bcd_sr, bin_sr} left by 1; the MSB of `bin_sr` enters the LSB of `bcd_sr`.
  - Decrement `count`.
  - On the edge where `count` goes 1→0: write the post-shift `bcd_sr` to `bcd_out`, assert `done`, go to IDLE.
- `count` width is clog2(WIDTH+1).
- The add-3 is a 4-bit add on nibbles ≤ 9, so no overflow is possible.
- `start` while in CONVERT is ignored and is not queued.
- `bin_in` changes after acceptance have no effect.
- Every nibble of `bcd_out` is 0–9 after any completed conversion. Codes 10–15 never appear.
- `done` is registered. It is high only in the cycle immediately after the final CONVERT edge.
- `busy` is registered and equals (state == CONVERT).
- Reset (`resetn`=0 on an edge), including mid-conversion: state = IDLE, `busy`=0, `done`=0, `bcd_out`=0, `bcd_sr`=0, `bin_sr`=0, `count`=0.
  - An aborted conversion never produces `done`.
  - `start` on the same edge as reset is ignored.

## Timing
- `start` accepted at edge E0. `busy`=1 from after E0 through the cycle before E(WIDTH).
- Iterations occur on edges E1 … E(WIDTH). `bcd_out` is valid and `done`=1 after edge E(WIDTH), for one cycle. `busy`=0 in that same cycle.
- Latency from accepting edge to result: WIDTH cycles (16 at default).
- The earliest next accepted `start` is edge E(WIDTH+1), i.e. `start` held high while `done`=1. Peak throughput is one conversion per WIDTH+1 cycles.
- `bcd_out` is unchanged during a conversion. It updates only on the completing edge, so the downstream decoders never display intermediate values.

## Test plan
- Reset, then `bin_in`=0 with a single `start` pulse → `done` pulses exactly 16 cycles after the accepting edge; `bcd_out`=20'h00000; `busy` is high for 16 cycles.
- `bin_in`=16'd65535 → `bcd_out`=20'h65535. Then `bin_in`=16'd1234 → 20'h01234. Then 16'd9 → 20'h00009. Then 16'd10 → 20'h00010.
- Start 16'd4321; pulse `start` again with 16'd999 at cycle 5 while busy → result 20'h04321; exactly one `done`; the second request is dropped.
- Hold `start`=1 continuously with 16'd500 then 16'd501 → conversions accepted every 17 cycles; `bcd_out` goes 20'h00500 then 20'h00501; `done` pulses are 17 cycles apart.
- Start 16'd777; assert `resetn`=0 at cycle 8 → `busy`, `done` and `bcd_out` are all 0 on the next edge; no `done` ever appears for 777. A new start with 16'd42 afterwards → 20'h00042.
- Random sweep of 1000 values with a reference model → every nibble ≤ 9 and the packed result matches the decimal value.
